// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer. It fetches, decodes and executes one instruction at a time,
// issues the memory handshakes, and pulses the PC/register-file write strobes once per retired instruction.
module pc_sequencer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        flag_z,
    input  logic        flag_c,
    input  logic        flag_s,
    output logic [31:0] instr,
    output logic        pc_en,
    output logic        branch,
    output logic        reg_en,
    output logic [25:0] L,
    output logic        reg_we,
    output logic        link_we,
    output logic        halted,
    output logic        fault,
    output logic [31:0] retired
);

    // Handshakes: a req holds high from state entry until the cycle its ack is sampled.
    // A missing ack is abandoned after ACK_TIMEOUT cycles, and the sequencer then faults into HALT.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       take, take_nxt;
    logic       fault_nxt;
    logic       cond_take;

    logic [5:0] opcode;
    logic       is_halt, is_mem, is_store, is_branch, is_br, is_bal;

    assign opcode    = instr[31:26];
    assign is_halt   = (opcode == 6'b111111);
    assign is_mem    = opcode[5] && !is_halt;
    assign is_store  = is_mem && opcode[0];
    assign is_branch = (opcode[5:3] == 3'b010);
    assign is_br     = (opcode == 6'b010001);
    assign is_bal    = (opcode == 6'b010111);
    assign L         = instr[25:0];

    always_comb begin
        case (opcode[2:0])
            3'd2:    cond_take = flag_z;
            3'd3:    cond_take = !flag_z;
            3'd4:    cond_take = flag_c;
            3'd5:    cond_take = !flag_c;
            3'd6:    cond_take = flag_s;
            default: cond_take = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            take     <= 1'b0;
            fault    <= 1'b0;
            instr    <= 32'd0;
            retired  <= 32'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            take     <= take_nxt;
            fault    <= fault_nxt;
            if (state == FETCH && imem_ack)
                instr <= imem_rdata;
            if (state == WB)
                retired <= retired + 32'd1;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        take_nxt     = take;
        fault_nxt    = fault;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        pc_en        = 1'b0;
        branch       = 1'b0;
        reg_en       = 1'b0;
        reg_we       = 1'b0;
        link_we      = 1'b0;
        halted       = 1'b0;
        case (state)
            IDLE: begin
                state_nxt    = FETCH;
                wait_cnt_nxt = 8'd0;
            end
            FETCH: begin
                imem_req = 1'b1;
                // An ack on the final allowed cycle takes priority over the timeout.
                if (imem_ack) begin
                    state_nxt = DECODE;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    state_nxt = HALT;
                    fault_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            DECODE: state_nxt = EXEC;
            EXEC: begin
                take_nxt = is_branch && cond_take;
                if (is_halt) begin
                    state_nxt = HALT;
                end else if (is_mem) begin
                    state_nxt    = MEM;
                    wait_cnt_nxt = 8'd0;
                end else begin
                    state_nxt = WB;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ack) begin
                    state_nxt = WB;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    state_nxt = HALT;
                    fault_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            WB: begin
                pc_en        = 1'b1;
                branch       = take;
                reg_en       = take && is_br;
                reg_we       = !is_branch && !is_store;
                link_we      = take && is_bal;
                state_nxt    = FETCH;
                wait_cnt_nxt = 8'd0;
            end
            HALT:    halted = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a table of single-instruction vectors checked through an expected-value
// queue, plus hand sequences for fetch timeout, the halt instruction and reset during a memory access.
module tb_pc_sequencer;

    localparam int ACK_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic        flag_z, flag_c, flag_s;
    logic [31:0] instr;
    logic        pc_en, branch, reg_en, reg_we, link_we, halted, fault;
    logic [25:0] L;
    logic [31:0] retired;

    always #5 clk = ~clk;

    pc_sequencer #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .flag_z(flag_z), .flag_c(flag_c), .flag_s(flag_s),
        .instr(instr), .pc_en(pc_en), .branch(branch), .reg_en(reg_en), .L(L),
        .reg_we(reg_we), .link_we(link_we), .halted(halted), .fault(fault), .retired(retired)
    );

    typedef struct {
        logic [31:0] w;
        logic        z, c, s;
        int          mem_wait;
        logic        br, re, rwe, lwe, dwe;
        int          lat;
    } vec_t;

    vec_t        vecs[15];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_retired;
    logic [29:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_retired = 32'd0;
        exp_q.delete();
        @(negedge clk);
        check("first_fetch", imem_req, 1'b1);
    endtask

    // Runs one instruction starting from a FETCH cycle; the ack is withheld for fetch_wait cycles.
    task automatic run_instr(input vec_t v, input int fetch_wait);
        int          cyc, lat, mem_cyc, exp_mem;
        bit          done;
        logic [29:0] e;
        cyc = 0;
        while (imem_req !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        lat = 1;
        for (int k = 0; k < fetch_wait; k++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("fetch_req_hold", imem_req, 1'b1);
        imem_ack   = 1'b1;
        imem_rdata = v.w;
        exp_q.push_back({v.br, v.re, v.rwe, v.lwe, v.w[25:0]});
        @(negedge clk);
        imem_ack = 1'b0;
        lat++;
        flag_z = v.z; flag_c = v.c; flag_s = v.s;
        @(negedge clk);
        lat++;
        @(negedge clk);
        lat++;
        flag_z = ~v.z; flag_c = ~v.c; flag_s = ~v.s;
        exp_mem = (v.w[31] && v.w[31:26] != 6'h3f) ? v.mem_wait + 1 : 0;
        mem_cyc = 0;
        done    = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (pc_en) begin
                dmem_ack = 1'b0;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 30'h3fffffff;
                check("latency", 32'(lat), 32'(v.lat + fetch_wait));
                check("mem_cycles", 32'(mem_cyc), 32'(exp_mem));
                check("branch", branch, e[29]);
                check("reg_en", reg_en, e[28]);
                check("reg_we", reg_we, e[27]);
                check("link_we", link_we, e[26]);
                check("L", 32'(L), 32'(e[25:0]));
                check("instr", instr, v.w);
                exp_retired = exp_retired + 32'd1;
                @(negedge clk);
                check("retired", retired, exp_retired);
                check("pc_en_pulse", pc_en, 1'b0);
                check("refetch", imem_req, 1'b1);
                done = 1'b1;
            end else begin
                if (dmem_req) begin
                    mem_cyc++;
                    check("dmem_we", dmem_we, v.dwe);
                    dmem_ack = (mem_cyc == v.mem_wait + 1);
                end else begin
                    dmem_ack = 1'b0;
                end
                @(negedge clk);
                lat++;
            end
        end
        check("pc_en_seen", 32'(done), 32'd1);
    endtask

    task automatic halt_seq();
        int cyc, pc_cnt, req_cnt;
        cyc = 0;
        while (imem_req !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hFC000000;
        pc_cnt  = 0;
        req_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            imem_ack = k[0];
            dmem_ack = ~k[0];
            if (pc_en) pc_cnt++;
            if (imem_req || dmem_req) req_cnt++;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        check("halt_halted", halted, 1'b1);
        check("halt_fault", fault, 1'b0);
        check("halt_pc_en", 32'(pc_cnt), 32'd0);
        check("halt_reqs", 32'(req_cnt), 32'd0);
        check("halt_retired", retired, exp_retired);
    endtask

    task automatic timeout_seq();
        int fetch_cycles;
        fetch_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            if (!imem_req) break;
            fetch_cycles++;
            imem_ack = 1'b0;
            @(negedge clk);
        end
        check("timeout_cycles", 32'(fetch_cycles), 32'(ACK_TIMEOUT));
        check("timeout_halted", halted, 1'b1);
        check("timeout_fault", fault, 1'b1);
        check("timeout_imem_req", imem_req, 1'b0);
        check("timeout_retired", retired, 32'd0);
    endtask

    task automatic mem_reset_seq();
        imem_ack   = 1'b1;
        imem_rdata = 32'h80000000;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_mem_req", dmem_req, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_dmem_req", dmem_req, 1'b0);
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_instr", instr, 32'd0);
        dmem_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_fetch", imem_req, 1'b1);
        check("post_rst_pc_en", pc_en, 1'b0);
        check("post_rst_retired", retired, 32'd0);
        dmem_ack = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{32'h00000000, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4};
        vecs[1]  = '{32'h48001234, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4};
        vecs[2]  = '{32'h4C000055, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4};
        vecs[3]  = '{32'h44000000, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4};
        vecs[4]  = '{32'h5C00ABCD, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4};
        vecs[5]  = '{32'h40000001, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4};
        vecs[6]  = '{32'h50000000, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4};
        vecs[7]  = '{32'h54000000, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4};
        vecs[8]  = '{32'h58000000, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4};
        vecs[9]  = '{32'h58000007, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4};
        vecs[10] = '{32'h80000000, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8};
        vecs[11] = '{32'h84000010, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5};
        vecs[12] = '{32'h3FFFFFFF, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4};
        vecs[13] = '{32'hF8000000, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6};
        vecs[14] = '{32'h48000000, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4};

        rst        = 1'b1;
        imem_ack   = 1'b0;
        dmem_ack   = 1'b0;
        imem_rdata = 32'd0;
        flag_z = 1'b0; flag_c = 1'b0; flag_s = 1'b0;
        #3;
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_dmem_req", dmem_req, 1'b0);
        check("rst_pc_en", pc_en, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_retired", retired, 32'd0);
        check("rst_instr", instr, 32'd0);

        do_reset();
        for (int i = 0; i < 15; i++)
            run_instr(vecs[i], $urandom_range(0, 2));
        run_instr(vecs[0], ACK_TIMEOUT - 1);
        check("late_ack_fault", fault, 1'b0);
        halt_seq();

        do_reset();
        timeout_seq();

        do_reset();
        mem_reset_seq();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL provide parameter ACK_TIMEOUT, default 16: maximum cycles to wait for imem_ack or dmem_ack before faulting (range 1..255).
REQ-002 Clock and reset SHALL be: reset rst, asynchronous, active-high; clock clk.
REQ-003 Ports, in order:
- clk  in  1  system clock
- rst  in  1  async active-high reset
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- dmem_req  out  1  data memory access request
- dmem_we  out  1  1 = store, 0 = load; valid with dmem_req
- dmem_ack  in  1  data access complete
- flag_z  in  1  ALU zero flag
- flag_c  in  1  ALU carry flag
- flag_s  in  1  ALU sign flag
- instr  out  32  latched current instruction
- pc_en  out  1  one-cycle PC update strobe to next_pc
- branch  out  1  select branch target at pc_en
- reg_en  out  1  select register target (jump-register)
- L  out  26  branch offset, instr[25:0]
- reg_we  out  1  register-file write strobe
- link_we  out  1  write PC+4 to link register (branch-and-link)
- halted  out  1  sequencer stopped
- fault  out  1  handshake timeout occurred
- retired  out  32  count of completed instructions

Function
REQ-004 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT (binary encoding).
REQ-005 Transitions SHALL be:
- IDLE->FETCH unconditionally.
- FETCH->DECODE on imem_ack.
- DECODE->EXEC.
- EXEC->MEM if opcode[5]=1 and opcode!=6'b111111; EXEC->HALT if opcode=6'b111111; otherwise EXEC->WB.
- MEM->WB on dmem_ack.
- WB->FETCH.
- HALT is terminal until rst.
REQ-006 Opcode SHALL be instr[31:26]. Decode:
- 010000 b (always taken).
- 010001 br (taken, reg_en=1).
- 010010 bz (taken if Z).
- 010011 bnz (taken if !Z).
- 010100 bcy (taken if C).
- 010101 bncy (taken if !C).
- 010110 bneg (taken if S).
- 010111 bal (taken, link_we=1).
- 1xxxx0 load (dmem_we=0, reg_we=1).
- 1xxxx1 except 111111: store (dmem_we=1, reg_we=0).
- 111111 halt.
- All other opcodes: ALU, reg_we=1.
REQ-007 imem_rdata SHALL be captured into instr on the FETCH cycle where imem_ack=1; instr SHALL hold until the next capture.
REQ-008 Flags SHALL be sampled in EXEC into a registered take bit; flag changes after EXEC SHALL NOT affect the current instruction.
REQ-009 Request outputs:
- imem_req SHALL be 1 exactly while in FETCH.
- dmem_req SHALL be 1 exactly while in MEM.
- A request SHALL NOT drop before its ack.
REQ-010 In WB, for exactly one cycle:
- pc_en=1.
- branch=take.
- reg_en=take AND opcode=br.
- reg_we and link_we per REQ-006, with link_we=1 only when taken.
- retired increments by 1.
Outside WB, all of these SHALL be 0.
REQ-011 L SHALL continuously equal instr[25:0].
REQ-012 An 8-bit wait counter SHALL clear on entry to FETCH and MEM and increment each cycle without ack. When it reaches ACK_TIMEOUT, the sequencer SHALL enter HALT with fault=1. An ack on the same cycle the counter reaches ACK_TIMEOUT SHALL win (no fault).
REQ-013 halt SHALL NOT assert pc_en or increment retired.
REQ-014 retired SHALL wrap from 32'hFFFFFFFF to 0.
REQ-015 Latency with same-cycle ack SHALL be 4 cycles for non-memory instructions and 5 cycles for load/store, measured from FETCH entry to pc_en.
REQ-016 In HALT: halted=1; all request and strobe outputs SHALL be 0; imem_ack and dmem_ack SHALL be ignored.

Reset
REQ-017 While rst=1, regardless of clk, the block SHALL be in state IDLE with: instr=0, retired=0, wait counter=0, halted=0, fault=0, and all request and strobe outputs 0.
REQ-018 rst asserted mid-FETCH or mid-MEM SHALL drop imem_req/dmem_req immediately; a subsequent ack SHALL be ignored.
REQ-019 After rst deasserts, the first posedge SHALL move IDLE->FETCH.

Verification
REQ-020 ALU instr 32'h00000000, imem_ack same cycle -> pc_en=1 with branch=0 and reg_we=1 on the 4th cycle after FETCH entry; retired=1.
REQ-021 bz with Z=1 in EXEC, then Z=0 in WB -> branch=1, reg_en=0, L=instr[25:0]; bnz under the same flags -> branch=0.
REQ-022 br instr 32'h44000000 -> branch=1, reg_en=1; bal -> link_we=1 with branch=1 in the same cycle.
REQ-023 Load 32'h80000000 with dmem_ack delayed 3 cycles -> dmem_req=1 for 4 cycles, dmem_we=0, reg_we=1 in WB, total latency 8 cycles.
REQ-024 imem_ack withheld, ACK_TIMEOUT=16 -> HALT with fault=1 after 16 FETCH cycles, imem_req=0; ack at cycle 16 instead -> normal DECODE.
REQ-025 halt 32'hFC000000 -> halted=1, no pc_en, retired unchanged; rst asserted mid-MEM -> dmem_req=0 in the same cycle, state IDLE.
